// File: rtl/rv_mem_pkg.sv
// Shared types for the data-memory port arbiter: request record, port ids and widths.
package rv_mem_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned STRB_W     = 8;
    // Widest byte address carried in mem_req_t; the arbiter's ADDR_W must not exceed it.
    localparam int unsigned ADDR_MAX_W = 32;

    typedef logic port_id_t;

    localparam port_id_t PORT_CPU = 1'b0;
    localparam port_id_t PORT_LDR = 1'b1;

    typedef struct packed {
        logic                  we;
        logic [ADDR_MAX_W-1:0] addr;
        logic [XLEN-1:0]       wdata;
        logic [STRB_W-1:0]     wstrb;
    } mem_req_t;

    function automatic port_id_t other_port(input port_id_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundle of both requester ports and the memory-side port of the arbiter.
interface dm_port_arbiter_if
    import rv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [XLEN-1:0]   m0_wdata;
    logic [STRB_W-1:0] m0_wstrb;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [XLEN-1:0]   m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [XLEN-1:0]   m1_wdata;
    logic [STRB_W-1:0] m1_wstrb;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [XLEN-1:0]   m1_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-4:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic [XLEN-1:0]   mem_rdata;

    // Requesters and the memory model together form the environment side.
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata
    );

endinterface

// File: rtl/dm_rr_sel.sv
// Round-robin grant selection with a bounded burst hold for two requesters.
module dm_rr_sel
    import rv_mem_pkg::*;
#(
    parameter int unsigned BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output port_id_t   gnt_id_o
);

    port_id_t   prio_q, prio_d;
    logic [3:0] bcnt_q, bcnt_d;

    // Grant decode: a lone requester wins, contention goes to prio; nothing during reset.
    always_comb begin
        gnt_o    = 2'b00;
        gnt_id_o = PORT_CPU;
        if (!rst) begin
            unique case (req_i)
                2'b01: begin
                    gnt_o    = 2'b01;
                    gnt_id_o = PORT_CPU;
                end
                2'b10: begin
                    gnt_o    = 2'b10;
                    gnt_id_o = PORT_LDR;
                end
                2'b11: begin
                    gnt_id_o = prio_q;
                    gnt_o    = (prio_q == PORT_LDR) ? 2'b10 : 2'b01;
                end
                default: begin
                    gnt_o    = 2'b00;
                    gnt_id_o = PORT_CPU;
                end
            endcase
        end
    end

    // Pointer/counter update: count contended grants, hand over after BURST of them.
    always_comb begin
        prio_d = prio_q;
        bcnt_d = bcnt_q;
        if (|gnt_o) begin
            if (&req_i) begin
                if (bcnt_q + 4'd1 == 4'(BURST)) begin
                    prio_d = other_port(gnt_id_o);
                    bcnt_d = 4'd0;
                end else begin
                    bcnt_d = bcnt_q + 4'd1;
                end
            end else begin
                // Uncontended grant: remember the last user, restart the burst window.
                prio_d = gnt_id_o;
                bcnt_d = 4'd0;
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= PORT_CPU;
            bcnt_q <= 4'd0;
        end else begin
            prio_q <= prio_d;
            bcnt_q <= bcnt_d;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of the single-port data memory, with a 1-cycle read return path.
module dm_port_arbiter
    import rv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned BURST  = 4
) (
    input logic             clk,
    input logic             rst,
    dm_port_arbiter_if.slave bus_io
);

    logic [1:0] gnt;
    port_id_t   gnt_id;
    mem_req_t   req0, req1, sel_req;
    logic       rd_pend_q, rd_pend_d;
    port_id_t   rd_tag_q, rd_tag_d;
    logic       unused_addr;

    dm_rr_sel #(
        .BURST (BURST)
    ) u_rr_sel (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({bus_io.m1_req, bus_io.m0_req}),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    // Pack each port's request fields.
    always_comb begin
        req0.we    = bus_io.m0_we;
        req0.addr  = ADDR_MAX_W'(bus_io.m0_addr);
        req0.wdata = bus_io.m0_wdata;
        req0.wstrb = bus_io.m0_wstrb;
        req1.we    = bus_io.m1_we;
        req1.addr  = ADDR_MAX_W'(bus_io.m1_addr);
        req1.wdata = bus_io.m1_wdata;
        req1.wstrb = bus_io.m1_wstrb;
    end

    // Route the granted request to memory; an idle cycle drives all zeros.
    always_comb begin
        sel_req = '0;
        if (gnt[0]) begin
            sel_req = req0;
        end else if (gnt[1]) begin
            sel_req = req1;
        end
    end

    assign bus_io.m0_gnt    = gnt[0];
    assign bus_io.m1_gnt    = gnt[1];
    assign bus_io.mem_en    = |gnt;
    assign bus_io.mem_we    = sel_req.we;
    assign bus_io.mem_addr  = sel_req.addr[ADDR_W-1:3];
    assign bus_io.mem_wdata = sel_req.wdata;
    assign bus_io.mem_wstrb = sel_req.wstrb;

    // Byte-offset bits and any address bits above ADDR_W are dropped on purpose.
    assign unused_addr = ^sel_req.addr;

    // Track which port owns the read data arriving next cycle.
    always_comb begin
        rd_pend_d = (|gnt) && !sel_req.we;
        rd_tag_d  = (|gnt) ? gnt_id : rd_tag_q;
    end

    // Response pipe registers; reset drops any in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rd_tag_q  <= PORT_CPU;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_tag_q  <= rd_tag_d;
        end
    end

    // Return read data only to the tagged port; gate with rst so nothing leaks during reset.
    always_comb begin
        bus_io.m0_rvalid = rd_pend_q && !rst && (rd_tag_q == PORT_CPU);
        bus_io.m1_rvalid = rd_pend_q && !rst && (rd_tag_q == PORT_LDR);
        bus_io.m0_rdata  = bus_io.m0_rvalid ? bus_io.mem_rdata : '0;
        bus_io.m1_rdata  = bus_io.m1_rvalid ? bus_io.mem_rdata : '0;
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed, table-driven bench for dm_port_arbiter (ADDR_W=16, BURST=4).
module tb_dm_port_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned BR = 4;

    typedef struct packed {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [63:0]   wdata;
        logic [7:0]    wstrb;
    } req_t;

    typedef struct packed {
        logic          gnt0;
        logic          gnt1;
        logic          en;
        logic          we;
        logic [AW-4:0] addr;
        logic [63:0]   wdata;
        logic [7:0]    wstrb;
        logic          rv0;
        logic          rv1;
        logic [63:0]   rd0;
        logic [63:0]   rd1;
    } exp_t;

    typedef struct {
        string       name;
        req_t        p0;
        req_t        p1;
        logic [63:0] mem_rd;
        exp_t        e;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dm_port_arbiter_if #(.ADDR_W(AW)) bus ();

    dm_port_arbiter #(
        .ADDR_W (AW),
        .BURST  (BR)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input req_t a, input req_t b, input logic [63:0] rd);
        bus.m0_req    = a.req;
        bus.m0_we     = a.we;
        bus.m0_addr   = a.addr;
        bus.m0_wdata  = a.wdata;
        bus.m0_wstrb  = a.wstrb;
        bus.m1_req    = b.req;
        bus.m1_we     = b.we;
        bus.m1_addr   = b.addr;
        bus.m1_wdata  = b.wdata;
        bus.m1_wstrb  = b.wstrb;
        bus.mem_rdata = rd;
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    function automatic exp_t sample();
        exp_t a;
        a.gnt0  = bus.m0_gnt;
        a.gnt1  = bus.m1_gnt;
        a.en    = bus.mem_en;
        a.we    = bus.mem_we;
        a.addr  = bus.mem_addr;
        a.wdata = bus.mem_wdata;
        a.wstrb = bus.mem_wstrb;
        a.rv0   = bus.m0_rvalid;
        a.rv1   = bus.m1_rvalid;
        a.rd0   = bus.m0_rdata;
        a.rd1   = bus.m1_rdata;
        return a;
    endfunction

    initial begin
        vec_t        vecs[9];
        req_t        idle;
        req_t        ra;
        req_t        rb;
        exp_t        act;
        exp_t        z;
        int          rr_exp[12];
        int          tail_exp[4];
        int          waited;
        logic        seen;

        checks   = 0;
        failures = 0;
        idle     = '0;
        z        = '0;

        vecs[0] = '{"idle", idle, idle, 64'h0, z};
        vecs[1] = '{"m0_load", '{1'b1, 1'b0, 16'h0020, 64'h0, 8'h00}, idle, 64'h0,
                    '{1'b1, 1'b0, 1'b1, 1'b0, 13'd4, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0, 64'h0}};
        vecs[2] = '{"m0_rvalid", idle, idle, 64'hDEAD_BEEF_0000_0001,
                    '{1'b0, 1'b0, 1'b0, 1'b0, 13'd0, 64'h0, 8'h00, 1'b1, 1'b0,
                      64'hDEAD_BEEF_0000_0001, 64'h0}};
        vecs[3] = '{"m1_store", idle, '{1'b1, 1'b1, 16'h0018, 64'h1122_3344_5566_7788, 8'h0F},
                    64'h0,
                    '{1'b0, 1'b1, 1'b1, 1'b1, 13'd3, 64'h1122_3344_5566_7788, 8'h0F, 1'b0,
                      1'b0, 64'h0, 64'h0}};
        vecs[4] = '{"store_no_rvalid", idle, idle, 64'hFFFF_0000_FFFF_0000, z};
        vecs[5] = '{"alt_m0", '{1'b1, 1'b0, 16'h0000, 64'h0, 8'h00}, idle, 64'h0,
                    '{1'b1, 1'b0, 1'b1, 1'b0, 13'd0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0, 64'h0}};
        vecs[6] = '{"alt_m1", idle, '{1'b1, 1'b0, 16'h0008, 64'h0, 8'h00}, 64'hA0A0_0000_0000_00A0,
                    '{1'b0, 1'b1, 1'b1, 1'b0, 13'd1, 64'h0, 8'h00, 1'b1, 1'b0,
                      64'hA0A0_0000_0000_00A0, 64'h0}};
        vecs[7] = '{"alt_m0b", '{1'b1, 1'b0, 16'h0017, 64'h0, 8'h00}, idle, 64'hA1A1_0000_0000_00A1,
                    '{1'b1, 1'b0, 1'b1, 1'b0, 13'd2, 64'h0, 8'h00, 1'b0, 1'b1, 64'h0,
                      64'hA1A1_0000_0000_00A1}};
        vecs[8] = '{"alt_tail", idle, idle, 64'hA2A2_0000_0000_00A2,
                    '{1'b0, 1'b0, 1'b0, 1'b0, 13'd0, 64'h0, 8'h00, 1'b1, 1'b0,
                      64'hA2A2_0000_0000_00A2, 64'h0}};

        rr_exp   = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        tail_exp = '{0, 0, 0, 1};

        // Reset with both ports requesting: nothing may be granted.
        rst = 1'b1;
        ra  = '{1'b1, 1'b0, 16'h0040, 64'h0, 8'h00};
        rb  = '{1'b1, 1'b0, 16'h0080, 64'h0, 8'h00};
        drive(ra, rb, 64'h0);
        @(negedge clk);
        act = sample();
        checks++;
        if (act !== z) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", act, z);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(idle, idle, 64'h0);

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].p0, vecs[i].p1, vecs[i].mem_rd);
            @(negedge clk);
            act = sample();
            checks++;
            if (act !== vecs[i].e) begin
                failures++;
                $display("FAIL %s: got %h expected %h", vecs[i].name, act, vecs[i].e);
            end
        end

        // Continuous contention: BURST grants each way, last m0 grant is a load.
        ra = '{1'b1, 1'b1, 16'h0100, 64'h0, 8'hFF};
        rb = '{1'b1, 1'b1, 16'h0200, 64'h0, 8'hFF};
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            ra.we = (i == 11) ? 1'b0 : 1'b1;
            drive(ra, rb, 64'h0);
            @(negedge clk);
            check_bit($sformatf("rr_gnt0[%0d]", i), bus.m0_gnt, rr_exp[i] == 0);
            check_bit($sformatf("rr_gnt1[%0d]", i), bus.m1_gnt, rr_exp[i] == 1);
            check_bit($sformatf("rr_en[%0d]", i), bus.mem_en, 1'b1);
        end

        // Reset right after the m0 load grant: its response must be dropped.
        @(posedge clk);
        #1;
        rst   = 1'b1;
        ra.we = 1'b1;
        drive(ra, rb, 64'h5555_5555_5555_5555);
        @(negedge clk);
        check_bit("rst_rvalid0", bus.m0_rvalid, 1'b0);
        check_bit("rst_en", bus.mem_en, 1'b0);
        check_bit("rst_gnt1", bus.m1_gnt, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_bit("post_rst_rvalid0", bus.m0_rvalid, 1'b0);
        check_bit("post_rst_gnt0", bus.m0_gnt, 1'b1);
        check_bit("post_rst_gnt1", bus.m1_gnt, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_bit($sformatf("post_rst_burst[%0d]", i), bus.m1_gnt, tail_exp[i] == 1);
        end

        // Loader alone for 10 cycles, then the CPU joins.
        ra.req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            drive(ra, rb, 64'h0);
            @(negedge clk);
            check_bit($sformatf("m1_only[%0d]", i), bus.m1_gnt, 1'b1);
        end
        ra.req = 1'b1;
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 20) begin
            @(posedge clk);
            #1;
            drive(ra, rb, 64'h0);
            @(negedge clk);
            if (bus.m0_gnt) begin
                seen = 1'b1;
            end else begin
                waited++;
            end
        end
        checks++;
        if (!seen || waited != int'(BR)) begin
            failures++;
            $display("FAIL starvation_bound: m0 granted=%0b after %0d waits expected %0d",
                     seen, waited, BR);
        end

        drive(idle, idle, 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
